// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment scan decoder: watches an active-low anode/segment bus, debounces
// each digit sample, decodes it to BCD and publishes a 4-digit frame once every digit is seen.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 1,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        collision,
  output logic        active
);

  localparam int unsigned HoldW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(STABLE_CYCLES);
  localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e            state_q, state_d;
  logic [10:0]       in_q, in_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              accepted_q, accepted_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [3:0][3:0]   digit_q, digit_d;
  logic [3:0]        err_q, err_d;
  logic [3:0]        seen_q, seen_d;
  logic [15:0]       bcd_q, bcd_d;
  logic              fv_q, fv_d;
  logic              ferr_q, ferr_d;
  logic              coll_q, coll_d;
  logic              active_q, active_d;

  logic [3:0] an_low;
  logic [6:0] seg_s;
  logic       digit_sample, coll_sample, in_change;
  logic       accept, complete, timeout_hit;
  logic [3:0] dec_nib;
  logic       dec_err;
  logic [1:0] pos;

  assign an_low       = ~in_q[10:7];
  assign seg_s        = in_q[6:0];
  assign digit_sample = $onehot(an_low);
  assign coll_sample  = !$onehot0(an_low);

  // Segment pattern to nibble; blank decodes to F without flagging an error.
  always_comb begin
    dec_nib = 4'hF;
    dec_err = 1'b0;
    case (seg_s)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b1111111: dec_nib = 4'hF;
      default:    dec_err = 1'b1;
    endcase
  end

  always_comb begin
    pos = 2'd0;
    case (an_low)
      4'b0010: pos = 2'd1;
      4'b0100: pos = 2'd2;
      4'b1000: pos = 2'd3;
      default: pos = 2'd0;
    endcase
  end

  always_comb begin
    in_d       = {an, seg};
    in_change  = (in_d != in_q);
    // accepted_q remembers that the current hold was already taken, so a long hold counts once.
    accept     = digit_sample && (hold_q == HoldMax) && !accepted_q;
    hold_d     = in_change ? HoldW'(1) : ((hold_q == HoldMax) ? hold_q : hold_q + 1'b1);
    accepted_d = in_change ? 1'b0 : (accepted_q | accept);

    digit_d  = digit_q;
    err_d    = err_q;
    seen_d   = seen_q;
    bcd_d    = bcd_q;
    fv_d     = 1'b0;
    ferr_d   = ferr_q;
    coll_d   = coll_q | coll_sample;
    active_d = active_q;
    state_d  = state_q;

    if (accept) begin
      digit_d[pos] = dec_nib;
      err_d[pos]   = dec_err;
      seen_d       = seen_q | an_low;
    end
    complete = accept && ((seen_q | an_low) == 4'hF);

    to_d        = accept ? '0 : ((to_q == ToMax) ? to_q : to_q + 1'b1);
    timeout_hit = !accept && (to_d == ToMax);

    if (complete) begin
      bcd_d    = digit_d;
      ferr_d   = |err_d;
      fv_d     = 1'b1;
      seen_d   = 4'b0000;
      active_d = 1'b1;
    end
    if (timeout_hit) begin
      active_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (accept && !complete) state_d = StCollect;
      end
      StCollect: begin
        if (complete) begin
          state_d = StIdle;
        end else if (timeout_hit) begin
          seen_d  = 4'b0000;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      in_q       <= '1;
      hold_q     <= '0;
      accepted_q <= 1'b0;
      to_q       <= '0;
      digit_q    <= {4{4'hF}};
      err_q      <= 4'b0000;
      seen_q     <= 4'b0000;
      bcd_q      <= 16'h0000;
      fv_q       <= 1'b0;
      ferr_q     <= 1'b0;
      coll_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_q       <= in_d;
      hold_q     <= hold_d;
      accepted_q <= accepted_d;
      to_q       <= to_d;
      digit_q    <= digit_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      bcd_q      <= bcd_d;
      fv_q       <= fv_d;
      ferr_q     <= ferr_d;
      coll_q     <= coll_d;
      active_q   <= active_d;
    end
  end

  assign bcd         = bcd_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign collision   = coll_q;
  assign active      = active_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: two instances (fast debounce / short timeout and slow debounce)
// share one stimulus stream and are checked against a sample-stream reference model.
module tb_seg7_scan_decoder;

  localparam logic [6:0] SEG_OF [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0000100};
  localparam int STAB [0:1] = '{1, 3};
  localparam int TMO  [0:1] = '{8, 20};

  logic        clock;
  logic        rst_r;
  logic [6:0]  seg_r;
  logic [3:0]  an_r;
  logic [15:0] bcd_a, bcd_b;
  logic        fv_a, fv_b, ferr_a, ferr_b, col_a, col_b, act_a, act_b;

  int errors = 0;
  int checks = 0;
  int fv_cnt_a = 0;
  int fv_cnt_b = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  logic [10:0] m_in   [2];
  int          m_run  [2];
  logic [3:0]  m_dig  [2][4];
  bit          m_err  [2][4];
  bit          m_seen [2][4];
  int          m_idle [2];
  logic [15:0] m_bcd  [2];
  bit          m_fv [2], m_ferr [2], m_col [2], m_act [2];

  typedef struct {
    logic [6:0] seg;
    logic [3:0] nib;
    logic       err;
  } dec_vec_t;
  dec_vec_t vecs [13];

  seg7_scan_decoder #(.STABLE_CYCLES(1), .TIMEOUT(8)) dut_a (
    .clock(clock), .reset(rst_r), .seg(seg_r), .an(an_r), .bcd(bcd_a),
    .frame_valid(fv_a), .frame_err(ferr_a), .collision(col_a), .active(act_a)
  );

  seg7_scan_decoder #(.STABLE_CYCLES(3), .TIMEOUT(20)) dut_b (
    .clock(clock), .reset(rst_r), .seg(seg_r), .an(an_r), .bcd(bcd_b),
    .frame_valid(fv_b), .frame_err(ferr_b), .collision(col_b), .active(act_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] seg_for(input int v);
    return (v < 10) ? SEG_OF[v] : 7'b1111111;
  endfunction

  function automatic void ref_decode(input logic [6:0] s, output logic [3:0] n, output bit e);
    n = 4'hF;
    e = (s != 7'b1111111);
    for (int d = 0; d < 10; d++) begin
      if (s == SEG_OF[d]) begin
        n = 4'(d);
        e = 0;
      end
    end
  endfunction

  // A digit is taken when its sample has been seen exactly STAB times in a row.
  task automatic model_step(input int i);
    logic [10:0] x;
    logic [3:0]  n;
    bit          e;
    int          nlow;
    int          p;
    bit          all;
    x = {an_r, seg_r};
    if (rst_r) begin
      m_in[i] = '1; m_run[i] = 0; m_idle[i] = 0; m_bcd[i] = 16'h0000;
      m_fv[i] = 0; m_ferr[i] = 0; m_col[i] = 0; m_act[i] = 0;
      for (int k = 0; k < 4; k++) begin
        m_dig[i][k] = 4'hF; m_err[i][k] = 0; m_seen[i][k] = 0;
      end
    end else begin
      nlow = 0;
      p = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_in[i][7+k] == 1'b0) begin
          nlow++;
          p = k;
        end
      end
      m_fv[i] = 0;
      if (nlow == 1 && m_run[i] == STAB[i]) begin
        ref_decode(m_in[i][6:0], n, e);
        m_dig[i][p] = n; m_err[i][p] = e; m_seen[i][p] = 1;
        m_idle[i] = 0;
        all = m_seen[i][0] & m_seen[i][1] & m_seen[i][2] & m_seen[i][3];
        if (all) begin
          m_bcd[i]  = {m_dig[i][3], m_dig[i][2], m_dig[i][1], m_dig[i][0]};
          m_ferr[i] = m_err[i][0] | m_err[i][1] | m_err[i][2] | m_err[i][3];
          m_fv[i]   = 1;
          m_act[i]  = 1;
          for (int k = 0; k < 4; k++) m_seen[i][k] = 0;
        end
      end else begin
        if (m_idle[i] < TMO[i]) m_idle[i]++;
        if (m_idle[i] == TMO[i]) begin
          m_act[i] = 0;
          for (int k = 0; k < 4; k++) m_seen[i][k] = 0;
        end
      end
      if (nlow >= 2) m_col[i] = 1;
      if (x == m_in[i]) begin
        if (m_run[i] < 100000) m_run[i]++;
      end else begin
        m_run[i] = 1;
      end
      m_in[i] = x;
    end
  endtask

  task automatic check_model(input int i, input logic [15:0] b, input logic fv, input logic fe,
                             input logic co, input logic ac);
    checks++;
    if (b !== m_bcd[i] || fv !== m_fv[i] || fe !== m_ferr[i] || co !== m_col[i] ||
        ac !== m_act[i]) begin
      errors++;
      $display("FAIL model[%0d] t=%0t got bcd=%h fv=%b ferr=%b col=%b act=%b expected bcd=%h fv=%b ferr=%b col=%b act=%b",
               i, $time, b, fv, fe, co, ac, m_bcd[i], m_fv[i], m_ferr[i], m_col[i], m_act[i]);
    end
  endtask

  task automatic check_eq(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] a, input logic [6:0] s);
    an_r  = a;
    seg_r = s;
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    check_model(0, bcd_a, fv_a, ferr_a, col_a, act_a);
    check_model(1, bcd_b, fv_b, ferr_b, col_b, act_b);
    if (fv_a) fv_cnt_a++;
    if (fv_b) fv_cnt_b++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b1111, 7'b1111111);
  endtask

  task automatic do_reset(input int n);
    rst_r = 1'b1;
    idle(n);
    rst_r = 1'b0;
  endtask

  task automatic digit(input int p, input logic [6:0] s, input int hold);
    logic [3:0] a;
    a = ~(4'b0001 << p);
    repeat (hold) cyc(a, s);
  endtask

  task automatic frame_raw(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input int hold);
    digit(0, s0, hold);
    digit(1, s1, hold);
    digit(2, s2, hold);
    digit(3, s3, hold);
    idle(2);
  endtask

  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    int         kind;
    int         hold;

    vecs[0]  = '{7'b0000001, 4'h0, 1'b0};
    vecs[1]  = '{7'b1001111, 4'h1, 1'b0};
    vecs[2]  = '{7'b0010010, 4'h2, 1'b0};
    vecs[3]  = '{7'b0000110, 4'h3, 1'b0};
    vecs[4]  = '{7'b1001100, 4'h4, 1'b0};
    vecs[5]  = '{7'b0100100, 4'h5, 1'b0};
    vecs[6]  = '{7'b0100000, 4'h6, 1'b0};
    vecs[7]  = '{7'b0001111, 4'h7, 1'b0};
    vecs[8]  = '{7'b0000000, 4'h8, 1'b0};
    vecs[9]  = '{7'b0000100, 4'h9, 1'b0};
    vecs[10] = '{7'b1111111, 4'hF, 1'b0};
    vecs[11] = '{7'b1111110, 4'hF, 1'b1};
    vecs[12] = '{7'b0110000, 4'hF, 1'b1};

    rst_r = 1'b1;
    an_r  = 4'b1111;
    seg_r = 7'b1111111;
    do_reset(3);
    check_eq("reset_bcd", bcd_a, 16'h0000);
    check_eq("reset_active", {15'd0, act_a}, 16'd0);
    check_eq("reset_collision", {15'd0, col_a}, 16'd0);

    // Basic frame, one digit per cycle.
    fv_cnt_a = 0;
    frame_raw(SEG_OF[4], SEG_OF[3], SEG_OF[2], SEG_OF[1], 1);
    check_eq("frame_1234_bcd", bcd_a, 16'h1234);
    check_eq("frame_1234_err", {15'd0, ferr_a}, 16'd0);
    check_eq("frame_1234_active", {15'd0, act_a}, 16'd1);
    check_eq("frame_1234_pulses", 16'(fv_cnt_a), 16'd1);

    // Undecodable digit 2.
    frame_raw(SEG_OF[4], SEG_OF[3], 7'b1111110, SEG_OF[1], 1);
    check_eq("bad_digit_bcd", bcd_a, 16'h1F34);
    check_eq("bad_digit_err", {15'd0, ferr_a}, 16'd1);

    // Collision inside a frame.
    fv_cnt_a = 0;
    digit(0, SEG_OF[4], 1);
    digit(1, SEG_OF[3], 1);
    cyc(4'b1100, SEG_OF[8]);
    digit(2, SEG_OF[2], 1);
    digit(3, SEG_OF[1], 1);
    idle(2);
    check_eq("collision_flag", {15'd0, col_a}, 16'd1);
    check_eq("collision_bcd", bcd_a, 16'h1234);
    check_eq("collision_pulses", 16'(fv_cnt_a), 16'd1);
    do_reset(1);
    check_eq("collision_cleared", {15'd0, col_a}, 16'd0);

    // Decode table.
    for (int k = 0; k < 13; k++) begin
      frame_raw(vecs[k].seg, SEG_OF[3], SEG_OF[2], SEG_OF[1], 1);
      check_eq($sformatf("decode_%0d_bcd", k), bcd_a, {4'h1, 4'h2, 4'h3, vecs[k].nib});
      check_eq($sformatf("decode_%0d_err", k), {15'd0, ferr_a}, {15'd0, vecs[k].err});
    end

    // Slow debounce instance: short holds ignored, long holds taken once each.
    do_reset(1);
    fv_cnt_b = 0;
    frame_raw(SEG_OF[4], SEG_OF[3], SEG_OF[2], SEG_OF[1], 2);
    check_eq("stable3_short_pulses", 16'(fv_cnt_b), 16'd0);
    frame_raw(SEG_OF[4], SEG_OF[3], SEG_OF[2], SEG_OF[1], 5);
    check_eq("stable3_long_pulses", 16'(fv_cnt_b), 16'd1);
    check_eq("stable3_long_bcd", bcd_b, 16'h1234);

    // Timeout discards a partial frame.
    frame_raw(SEG_OF[4], SEG_OF[3], SEG_OF[2], SEG_OF[1], 1);
    fv_cnt_a = 0;
    digit(0, SEG_OF[5], 1);
    digit(1, SEG_OF[6], 1);
    idle(10);
    check_eq("timeout_active", {15'd0, act_a}, 16'd0);
    check_eq("timeout_bcd_held", bcd_a, 16'h1234);
    digit(2, SEG_OF[7], 1);
    digit(3, SEG_OF[9], 1);
    digit(0, SEG_OF[5], 1);
    digit(1, SEG_OF[6], 1);
    idle(2);
    check_eq("timeout_pulses", 16'(fv_cnt_a), 16'd1);
    check_eq("timeout_new_bcd", bcd_a, 16'h9765);

    // Reset mid-frame.
    do_reset(1);
    fv_cnt_a = 0;
    digit(0, SEG_OF[4], 1);
    digit(1, SEG_OF[3], 1);
    digit(2, SEG_OF[2], 1);
    do_reset(1);
    digit(3, SEG_OF[1], 1);
    idle(2);
    check_eq("midreset_pulses", 16'(fv_cnt_a), 16'd0);
    check_eq("midreset_bcd", bcd_a, 16'h0000);

    // Random scan traffic against the model.
    for (int n = 0; n < 700; n++) begin
      kind = $urandom_range(0, 39);
      hold = $urandom_range(1, 6);
      if (kind == 0) begin
        idle($urandom_range(1, 25));
      end else if (kind == 1) begin
        ra = ~(4'b0011 << $urandom_range(0, 2));
        rs = 7'($urandom);
        repeat (hold) cyc(ra, rs);
      end else if (kind == 2) begin
        do_reset($urandom_range(1, 2));
      end else if (kind < 6) begin
        digit($urandom_range(0, 3), 7'($urandom), hold);
      end else begin
        digit($urandom_range(0, 3), seg_for($urandom_range(0, 10)), hold);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
